// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 Hz timing constants shared by the VGA sync generator.
//   Exports the default display/porch/sync sizes, the derived line and frame totals,
//   the coordinate counter width and the sync polarity.
package vga_pkg;
   localparam int VGA_H_DISPLAY = 640;
   localparam int VGA_H_FRONT   = 16;
   localparam int VGA_H_SYNC    = 96;
   localparam int VGA_H_BACK    = 48;
   localparam int VGA_V_DISPLAY = 480;
   localparam int VGA_V_FRONT   = 10;
   localparam int VGA_V_SYNC    = 2;
   localparam int VGA_V_BACK    = 33;
   localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
   localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;
   localparam int CNT_W         = 10;
   localparam logic SYNC_ACTIVE = 1'b0;
endpackage

// File: rtl/vga_mod_counter.sv
// vga_mod_counter: modulo-MOD up counter.
//   clk   : clock
//   clr   : synchronous clear, overrides en
//   en    : count enable
//   count : current value, 0..MOD-1
//   wrap  : high when en is set and count is at MOD-1 (count returns to 0 next clk)
module vga_mod_counter #(
   parameter int MOD = 800,
   parameter int W   = 10
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap
);
   localparam logic [W-1:0] LAST = W'(MOD - 1);
   assign wrap = en && (count == LAST);
   always_ff @(posedge clk)
      count <= (clr || wrap) ? '0 : en ? count + W'(1) : count;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator advancing one pixel per pix_en pulse.
//   clk         : system clock
//   reset       : synchronous reset, active-low
//   pix_en      : pixel-rate enable
//   hsync/vsync : sync pulses, active-low
//   video_on    : pixel_x/pixel_y lie in the visible area
//   pixel_x/y   : current pixel coordinates
//   frame_tick  : one-clk pulse with the first (0,0) output of each frame
//   frame_count : frame counter, present only when VGA_SYNC_FRAME_CNT_EN is defined
// All outputs are registered decodes of the same counter state, one clk behind it.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int H_DISPLAY = VGA_H_DISPLAY,
   parameter int H_FRONT   = VGA_H_FRONT,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BACK    = VGA_H_BACK,
   parameter int V_DISPLAY = VGA_V_DISPLAY,
   parameter int V_FRONT   = VGA_V_FRONT,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BACK    = VGA_V_BACK
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pix_en,
   output logic             hsync,
   output logic             vsync,
   output logic             video_on,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
`ifdef VGA_SYNC_FRAME_CNT_EN
   output logic [15:0]      frame_count,
`endif
   output logic             frame_tick
);
   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam logic [CNT_W-1:0] H_VIS = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_VIS = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_DISPLAY + H_FRONT);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_DISPLAY + V_FRONT);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);
   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             h_wrap, v_wrap, wrap_d;
   vga_mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_h (
      .clk(clk), .clr(!reset), .en(pix_en), .count(h_cnt), .wrap(h_wrap)
   );
   vga_mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_v (
      .clk(clk), .clr(!reset), .en(h_wrap), .count(v_cnt), .wrap(v_wrap)
   );
   // wrap_d marks that the counters just returned to (0,0) by wrapping, so the
   // tick lands on the same clk as the registered (0,0) outputs and never on
   // the (0,0) that follows reset release.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hsync      <= ~SYNC_ACTIVE;
         vsync      <= ~SYNC_ACTIVE;
         video_on   <= 1'b0;
         pixel_x    <= '0;
         pixel_y    <= '0;
         frame_tick <= 1'b0;
         wrap_d     <= 1'b0;
      end else begin
         hsync      <= (h_cnt >= HS_BEG && h_cnt < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync      <= (v_cnt >= VS_BEG && v_cnt < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         video_on   <= (h_cnt < H_VIS) && (v_cnt < V_VIS);
         pixel_x    <= h_cnt;
         pixel_y    <= v_cnt;
         frame_tick <= wrap_d;
         wrap_d     <= v_wrap;
      end
   end
`ifdef VGA_SYNC_FRAME_CNT_EN
   always_ff @(posedge clk)
      frame_count <= !reset ? '0 : frame_count + 16'(wrap_d);
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed self-checking bench for vga_sync_gen (full-size and shrunk timing).
module tb_vga_sync_gen;
   logic clk = 1'b0, reset = 1'b0, pix_en = 1'b0, s_reset = 1'b0, s_en = 1'b0;
   logic m_hs, m_vs, m_vo, m_ft, s_hs, s_vs, s_vo, s_ft;
   logic [9:0] m_x, m_y, s_x, s_y;
`ifdef VGA_SYNC_FRAME_CNT_EN
   logic [15:0] m_fc, s_fc;
`endif
   int total = 0, bad = 0;
   logic [23:0] exp_v;
   always #5 clk = ~clk;

   vga_sync_gen u_main (
      .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(m_hs), .vsync(m_vs),
      .video_on(m_vo), .pixel_x(m_x), .pixel_y(m_y),
`ifdef VGA_SYNC_FRAME_CNT_EN
      .frame_count(m_fc),
`endif
      .frame_tick(m_ft)
   );

   // Shrunk timing: 15 pixels x 8 lines = 120 pixels per frame.
   vga_sync_gen #(
      .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
   ) u_small (
      .clk(clk), .reset(s_reset), .pix_en(s_en), .hsync(s_hs), .vsync(s_vs),
      .video_on(s_vo), .pixel_x(s_x), .pixel_y(s_y),
`ifdef VGA_SYNC_FRAME_CNT_EN
      .frame_count(s_fc),
`endif
      .frame_tick(s_ft)
   );

   task automatic step(input logic en);
      pix_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic sstep(input logic en);
      s_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 8; i++) begin
         step(i % 4 == 0);
         total++;
         if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== {4'b1100, 20'd0}) begin
            bad++;
            $display("FAIL reset_state cyc=%0d got=%h want=%h", i, {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, {4'b1100, 20'd0});
         end
      end
      reset = 1'b1;
      step(1'b0);
      total++;
      if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== {4'b1110, 20'd0}) begin
         bad++;
         $display("FAIL reset_release got=%h want=%h", {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, {4'b1110, 20'd0});
      end
   endtask

   task automatic test_line;
      int lows = 0, first_low = -1, vis = 0;
      for (int x = 0; x < 800; x++) begin
         step(1'b0);
         exp_v = {!(x >= 656 && x < 752), 1'b1, x < 640, 1'b0, 10'(x), 10'd0};
         total++;
         if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== exp_v) begin
            bad++;
            $display("FAIL line x=%0d got=%h want=%h", x, {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, exp_v);
         end
         if (!m_hs) begin
            lows++;
            if (first_low < 0) first_low = int'(m_x);
         end
         if (m_vo) vis++;
         step(1'b1);
         step(1'b0);
         step(1'b0);
      end
      total++;
      if (lows != 96) begin
         bad++;
         $display("FAIL hsync_width got=%0d want=96", lows);
      end
      total++;
      if (first_low != 656) begin
         bad++;
         $display("FAIL hsync_start got=%0d want=656", first_low);
      end
      total++;
      if (vis != 640) begin
         bad++;
         $display("FAIL video_width got=%0d want=640", vis);
      end
      step(1'b0);
      total++;
      if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== {4'b1110, 10'd0, 10'd1}) begin
         bad++;
         $display("FAIL line_wrap got=%h want=%h", {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, {4'b1110, 10'd0, 10'd1});
      end
   endtask

   task automatic test_hold_back_to_back;
      for (int i = 0; i < 300; i++) step(1'b1);
      for (int i = 0; i < 1000; i++) begin
         step(1'b0);
         total++;
         if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== {4'b1110, 10'd300, 10'd1}) begin
            bad++;
            $display("FAIL hold cyc=%0d got=%h want=%h", i, {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, {4'b1110, 10'd300, 10'd1});
         end
      end
      for (int i = 0; i < 600; i++) begin
         int xi, x;
         step(1'b1);
         xi = 300 + i;
         x = xi % 800;
         exp_v = {!(x >= 656 && x < 752), 1'b1, x < 640, 1'b0, 10'(x), (xi < 800) ? 10'd1 : 10'd2};
         total++;
         if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== exp_v) begin
            bad++;
            $display("FAIL back_to_back i=%0d got=%h want=%h", i, {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, exp_v);
         end
      end
   endtask

   task automatic test_mid_reset;
      for (int i = 0; i < 200; i++) step(1'b1);
      step(1'b0);
      total++;
      if ({m_x, m_y} !== {10'd300, 10'd2}) begin
         bad++;
         $display("FAIL pre_reset_pos got=%h want=%h", {m_x, m_y}, {10'd300, 10'd2});
      end
      reset = 1'b0;
      step(1'b1);
      total++;
      if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== {4'b1100, 20'd0}) begin
         bad++;
         $display("FAIL reset_wins got=%h want=%h", {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, {4'b1100, 20'd0});
      end
      reset = 1'b1;
      step(1'b0);
      total++;
      if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== {4'b1110, 20'd0}) begin
         bad++;
         $display("FAIL mid_reset_restart got=%h want=%h", {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, {4'b1110, 20'd0});
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1);
         total++;
         if ({m_hs, m_vs, m_vo, m_ft, m_x, m_y} !== {4'b1110, 10'(i), 10'd0}) begin
            bad++;
            $display("FAIL resume i=%0d got=%h want=%h", i, {m_hs, m_vs, m_vo, m_ft, m_x, m_y}, {4'b1110, 10'(i), 10'd0});
         end
      end
   endtask

   task automatic test_small_frame;
      int ticks = 0, vlow = 0;
      s_reset = 1'b0;
      sstep(1'b0);
      s_reset = 1'b1;
      for (int k = 0; k < 245; k++) begin
         int x, y;
         sstep(1'b1);
         x = k % 15;
         y = (k / 15) % 8;
         exp_v = {!(x >= 10 && x < 13), !(y >= 5 && y < 7), x < 8 && y < 4,
                  k % 120 == 0 && k > 0, 10'(x), 10'(y)};
         total++;
         if ({s_hs, s_vs, s_vo, s_ft, s_x, s_y} !== exp_v) begin
            bad++;
            $display("FAIL small_frame k=%0d got=%h want=%h", k, {s_hs, s_vs, s_vo, s_ft, s_x, s_y}, exp_v);
         end
         if (k < 240) begin
            if (s_ft) ticks++;
            if (!s_vs) vlow++;
         end
      end
      total++;
      if (ticks != 1) begin
         bad++;
         $display("FAIL small_ticks got=%0d want=1", ticks);
      end
      total++;
      if (vlow != 60) begin
         bad++;
         $display("FAIL small_vsync_width got=%0d want=60", vlow);
      end
   endtask

   task automatic test_frame_period;
      int c = 0, n = 0;
      while (!s_ft && c < 1000) begin
         sstep(c % 4 == 0);
         c++;
      end
      total++;
      if (!s_ft) begin
         bad++;
         $display("FAIL tick_wait got=timeout want=tick");
      end else begin
         do begin
            sstep(c % 4 == 0);
            c++;
            n++;
            if (n == 1) begin
               total++;
               if (s_ft !== 1'b0) begin
                  bad++;
                  $display("FAIL tick_width got=%b want=0", s_ft);
               end
            end
         end while (!s_ft && n < 2000);
         total++;
         if (n != 480) begin
            bad++;
            $display("FAIL tick_period got=%0d want=480", n);
         end
      end
   endtask

`ifdef VGA_SYNC_FRAME_CNT_EN
   task automatic test_frame_count;
      s_reset = 1'b0;
      sstep(1'b0);
      s_reset = 1'b1;
      total++;
      if (s_fc !== 16'd0) begin
         bad++;
         $display("FAIL fc_reset got=%0d want=0", s_fc);
      end
      for (int k = 0; k < 361; k++) sstep(1'b1);
      total++;
      if (s_fc !== 16'd3) begin
         bad++;
         $display("FAIL fc_three got=%0d want=3", s_fc);
      end
      force u_small.frame_count = 16'hFFFF;
      #1;
      release u_small.frame_count;
      for (int k = 0; k < 120; k++) sstep(1'b1);
      total++;
      if (s_fc !== 16'd0) begin
         bad++;
         $display("FAIL fc_wrap got=%0d want=0", s_fc);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_line();
      test_hold_back_to_back();
      test_mid_reset();
      test_small_frame();
      test_frame_period();
`ifdef VGA_SYNC_FRAME_CNT_EN
      test_frame_count();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
